// File: rtl/banner_pkg.sv
// Shared colour codes, result encoding and text-line selectors for the winner banner.
package banner_pkg;

    localparam logic [2:0] BLACK     = 3'b000;
    localparam logic [2:0] WHITE     = 3'b111;
    localparam logic [2:0] RED       = 3'b100;
    localparam logic [2:0] GREEN     = 3'b010;
    localparam logic [2:0] BLUE      = 3'b001;
    localparam logic [2:0] YELLOW    = 3'b110;
    localparam logic [2:0] MAGENTA   = 3'b101;
    localparam logic [2:0] LIGHTBLUE = 3'b011;

    localparam logic [3:0] SCORE_MAX = 4'd9;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_XWIN = 2'd1,
        RES_OWIN = 2'd2,
        RES_TIE  = 2'd3
    } result_t;

    typedef enum logic [1:0] {
        LINE_NONE  = 2'd0,
        LINE_TITLE = 2'd1,
        LINE_SCORE = 2'd2
    } line_t;

    function automatic logic [6:0] bcd_ascii(input logic [3:0] d);
        return 7'h30 + {3'b000, d};
    endfunction

endpackage

// File: rtl/winner_banner_if.sv
// Pixel-side bus of the banner: scan coordinates and font ROM in, colour out.
interface winner_banner_if;
    logic        pixel_tick;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [7:0]  font_word;
    logic [10:0] rom_addr;
    logic [2:0]  text_on_winner;
    logic [2:0]  text_rgb;

    modport master (
        output pixel_tick, pix_x, pix_y, font_word,
        input  rom_addr, text_on_winner, text_rgb
    );

    modport slave (
        input  pixel_tick, pix_x, pix_y, font_word,
        output rom_addr, text_on_winner, text_rgb
    );
endinterface

// File: rtl/banner_text_rom.sv
// Combinational character lookup for the title ("Winner: X/O", "Tie") and score lines.
module banner_text_rom
    import banner_pkg::*;
(
    input  line_t       line,
    input  logic [3:0]  col,
    input  result_t     result,
    input  logic [3:0]  score_x,
    input  logic [3:0]  score_o,
    output logic [6:0]  char_code
);

    always_comb begin
        char_code = 7'h00;
        case (line)
            LINE_TITLE: begin
                if (result == RES_XWIN || result == RES_OWIN) begin
                    case (col)
                        4'd0: char_code = 7'h57;
                        4'd1: char_code = 7'h69;
                        4'd2: char_code = 7'h6E;
                        4'd3: char_code = 7'h6E;
                        4'd4: char_code = 7'h65;
                        4'd5: char_code = 7'h72;
                        4'd6: char_code = 7'h3A;
                        4'd7: char_code = 7'h20;
                        4'd8: char_code = (result == RES_XWIN) ? 7'h58 : 7'h4F;
                        default: char_code = 7'h00;
                    endcase
                end else if (result == RES_TIE) begin
                    case (col)
                        4'd0: char_code = 7'h54;
                        4'd1: char_code = 7'h69;
                        4'd2: char_code = 7'h65;
                        default: char_code = 7'h00;
                    endcase
                end
            end
            LINE_SCORE: begin
                case (col)
                    4'd0: char_code = 7'h58;
                    4'd1: char_code = 7'h3A;
                    4'd2: char_code = bcd_ascii(score_x);
                    4'd3: char_code = 7'h20;
                    4'd4: char_code = 7'h20;
                    4'd5: char_code = 7'h4F;
                    4'd6: char_code = 7'h3A;
                    4'd7: char_code = bcd_ascii(score_o);
                    default: char_code = 7'h00;
                endcase
            end
            default: char_code = 7'h00;
        endcase
    end

endmodule

// File: rtl/winner_banner.sv
// End-of-game banner: latches the result, keeps BCD win counts and draws a
// blinking title plus a steady score line through a 2-stage font pipeline.
module winner_banner
    import banner_pkg::*;
#(
    parameter int SCALE_LOG2   = 2,
    parameter int TITLE_ROW    = 1,
    parameter int SCORE_ROW    = 2,
    parameter int COL0         = 3,
    parameter int BLINK_FRAMES = 30
) (
    input  logic            clk,
    input  logic            reset,
    winner_banner_if.slave  vid,
    input  logic            ganadorX,
    input  logic            ganadorO,
    input  logic            tie,
    input  logic            new_game,
    output logic [3:0]      score_x,
    output logic [3:0]      score_o
);

    localparam int         CW_LOG2    = SCALE_LOG2 + 3;
    localparam logic [9:0] COL_LO     = 10'(COL0);
    localparam logic [9:0] COL_HI     = 10'(COL0 + 15);
    localparam logic [9:0] TITLE_IDX  = 10'(TITLE_ROW);
    localparam logic [9:0] SCORE_IDX  = 10'(SCORE_ROW);
    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    result_t    result, result_nxt;
    logic       x_d, o_d, tie_d;
    logic       x_rise, o_rise, tie_rise;
    logic       latch, inc_x, inc_o;
    logic [7:0] frame_cnt;
    logic       blink_phase;
    logic       frame_tick;

    always_ff @(posedge clk) begin
        if (reset) {x_d, o_d, tie_d} <= '0;
        else       {x_d, o_d, tie_d} <= {ganadorX, ganadorO, tie};
    end

    assign x_rise   = ganadorX & ~x_d;
    assign o_rise   = ganadorO & ~o_d;
    assign tie_rise = tie & ~tie_d;

    always_ff @(posedge clk) begin
        if (reset) result <= RES_NONE;
        else       result <= result_nxt;
    end

    always_comb begin
        result_nxt = result;
        if (new_game) begin
            result_nxt = RES_NONE;
        end else if (result == RES_NONE) begin
            if (tie_rise || (x_rise && o_rise)) result_nxt = RES_TIE;
            else if (x_rise)                    result_nxt = RES_XWIN;
            else if (o_rise)                    result_nxt = RES_OWIN;
        end
    end

    always_comb begin
        latch = (result == RES_NONE) && (result_nxt != RES_NONE);
        inc_x = latch && (result_nxt == RES_XWIN);
        inc_o = latch && (result_nxt == RES_OWIN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            score_x <= '0;
            score_o <= '0;
        end else begin
            if (inc_x && score_x != SCORE_MAX) score_x <= score_x + 4'd1;
            if (inc_o && score_o != SCORE_MAX) score_o <= score_o + 4'd1;
        end
    end

    assign frame_tick = vid.pixel_tick && (vid.pix_x == '0) && (vid.pix_y == '0);

    // A fresh result restarts the blink so it is first seen in its lit phase.
    always_ff @(posedge clk) begin
        if (reset || latch) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (frame_tick) begin
            if (frame_cnt == BLINK_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    logic [9:0] col_idx, grow_idx;
    logic [3:0] col_off;
    line_t      line_s0;
    logic [6:0] char_s0;
    logic       unused_pix;

    assign col_idx    = vid.pix_x >> CW_LOG2;
    assign grow_idx   = vid.pix_y >> (CW_LOG2 + 1);
    assign col_off    = 4'(col_idx - COL_LO);
    assign unused_pix = ^{vid.pix_x, vid.pix_y};

    always_comb begin
        line_s0 = LINE_NONE;
        if (col_idx >= COL_LO && col_idx < COL_HI) begin
            if (grow_idx == TITLE_IDX)      line_s0 = LINE_TITLE;
            else if (grow_idx == SCORE_IDX) line_s0 = LINE_SCORE;
        end
    end

    banner_text_rom u_text (
        .line      (line_s0),
        .col       (col_off),
        .result    (result),
        .score_x   (score_x),
        .score_o   (score_o),
        .char_code (char_s0)
    );

    assign vid.rom_addr = {char_s0, vid.pix_y[SCALE_LOG2+3:SCALE_LOG2]};

    logic [2:0] bit_addr_s1;
    line_t      line_s1;
    logic       on_s1;
    logic       lit, visible;
    logic [2:0] rgb_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_addr_s1 <= '0;
            line_s1     <= LINE_NONE;
            on_s1       <= 1'b0;
        end else if (vid.pixel_tick) begin
            bit_addr_s1 <= vid.pix_x[SCALE_LOG2+2:SCALE_LOG2];
            line_s1     <= line_s0;
            on_s1       <= (line_s0 != LINE_NONE);
        end
    end

    always_comb begin
        lit     = on_s1 && vid.font_word[~bit_addr_s1];
        visible = lit && !(line_s1 == LINE_TITLE && blink_phase);
        rgb_nxt = BLACK;
        if (visible) rgb_nxt = (line_s1 == LINE_TITLE) ? GREEN : WHITE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vid.text_rgb       <= BLACK;
            vid.text_on_winner <= '0;
        end else if (vid.pixel_tick) begin
            vid.text_rgb       <= rgb_nxt;
            vid.text_on_winner <= {1'b0, visible, 1'b0};
        end
    end

endmodule

// File: tb/tb_winner_banner.sv
// Directed scoreboard bench for winner_banner with a 2-frame blink half-period.
module tb_winner_banner;
    import banner_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       ganadorX, ganadorO, tie, new_game;
    logic [3:0] score_x, score_o;

    winner_banner_if vif();

    winner_banner #(
        .SCALE_LOG2   (2),
        .TITLE_ROW    (1),
        .SCORE_ROW    (2),
        .COL0         (3),
        .BLINK_FRAMES (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .vid      (vif),
        .ganadorX (ganadorX),
        .ganadorO (ganadorO),
        .tie      (tie),
        .new_game (new_game),
        .score_x  (score_x),
        .score_o  (score_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    // Coordinates: glyph cell is 32x64, title row y=64.., score row y=128..
    localparam logic [9:0] X_COL8  = 10'd352;
    localparam logic [9:0] X_COL0  = 10'd96;
    localparam logic [9:0] X_COL2  = 10'd160;
    localparam logic [9:0] X_COL7  = 10'd320;
    localparam logic [9:0] X_OUTR  = 10'd576;
    localparam logic [9:0] X_OUTL  = 10'd64;
    localparam logic [9:0] Y_TITLE = 10'd64;
    localparam logic [9:0] Y_SCORE = 10'd128;
    localparam logic [9:0] Y_SC_R3 = 10'd140;
    localparam logic [9:0] Y_BLANK = 10'd320;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    task automatic peek_rom(input logic [9:0] x, input logic [9:0] y);
        vif.pixel_tick = 1'b0;
        vif.pix_x      = x;
        vif.pix_y      = y;
        #1;
    endtask

    task automatic show_pixel(input logic [9:0] x, input logic [9:0] y, input logic [7:0] f);
        vif.pixel_tick = 1'b1;
        vif.pix_x      = x;
        vif.pix_y      = y;
        vif.font_word  = f;
        tick();
        tick();
        vif.pixel_tick = 1'b0;
    endtask

    task automatic frame_step();
        vif.pixel_tick = 1'b1;
        vif.pix_x      = '0;
        vif.pix_y      = '0;
        tick();
        vif.pixel_tick = 1'b0;
    endtask

    task automatic x_round();
        ganadorX = 1'b1;
        tick();
        ganadorX = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        ganadorX = 1'b0; ganadorO = 1'b0; tie = 1'b0; new_game = 1'b0;
        vif.pixel_tick = 1'b0; vif.pix_x = '0; vif.pix_y = '0; vif.font_word = '0;
        tick();
        tick();
        reset = 1'b0;

        expect_val(32'd0);   check("reset_score_x", 32'(score_x));
        expect_val(32'd0);   check("reset_score_o", 32'(score_o));
        expect_val(32'd0);   check("reset_rgb", 32'(vif.text_rgb));
        expect_val(32'd0);   check("reset_text_on", 32'(vif.text_on_winner));
        peek_rom(X_COL2, Y_SC_R3);
        expect_val(32'h303); check("reset_score_char", 32'(vif.rom_addr));
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h000); check("reset_title_blank", 32'(vif.rom_addr));

        // First X win, then hold the flag high
        ganadorX = 1'b1;
        expect_val(32'd1);
        tick();
        check("xwin_score_x", 32'(score_x));
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h580); check("xwin_title_char", 32'(vif.rom_addr));
        expect_val(32'd1);
        repeat (100) tick();
        check("xwin_hold_score_x", 32'(score_x));
        ganadorX = 1'b0;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h000); check("new_game_blank", 32'(vif.rom_addr));
        expect_val(32'd1);   check("new_game_keeps_score", 32'(score_x));

        // X and O together latch TIE
        ganadorX = 1'b1; ganadorO = 1'b1;
        expect_val(32'd1); expect_val(32'd0);
        tick();
        check("tie_xo_score_x", 32'(score_x));
        check("tie_xo_score_o", 32'(score_o));
        peek_rom(X_COL0, Y_TITLE);
        expect_val(32'h540); check("tie_title_char", 32'(vif.rom_addr));
        ganadorX = 1'b0; ganadorO = 1'b0; new_game = 1'b1;
        tick();
        new_game = 1'b0;

        // O win
        ganadorO = 1'b1;
        expect_val(32'd1);
        tick();
        check("owin_score_o", 32'(score_o));
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h4F0); check("owin_title_char", 32'(vif.rom_addr));
        ganadorO = 1'b0; new_game = 1'b1;
        tick();
        new_game = 1'b0;

        // new_game beats a coincident rising edge
        new_game = 1'b1; ganadorX = 1'b1;
        expect_val(32'd1);
        tick();
        new_game = 1'b0;
        check("newgame_prio_score_x", 32'(score_x));
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h000); check("newgame_prio_blank", 32'(vif.rom_addr));
        ganadorX = 1'b0;
        tick();

        // tie flag alone
        tie = 1'b1;
        tick();
        tie = 1'b0;
        peek_rom(X_COL0, Y_TITLE);
        expect_val(32'h540); check("tie_flag_char", 32'(vif.rom_addr));
        expect_val(32'd1);   check("tie_flag_score_x", 32'(score_x));
        new_game = 1'b1;
        tick();
        new_game = 1'b0;

        // Saturation at 9
        for (int i = 0; i < 10; i++) x_round();
        expect_val(32'd9);   check("sat_score_x", 32'(score_x));
        peek_rom(X_COL2, Y_SC_R3);
        expect_val(32'h393); check("sat_score_char", 32'(vif.rom_addr));
        peek_rom(X_COL7, Y_SC_R3);
        expect_val(32'h313); check("score_o_char", 32'(vif.rom_addr));
        peek_rom(X_OUTR, Y_SC_R3);
        expect_val(32'h003); check("col_right_out", 32'(vif.rom_addr));
        peek_rom(X_OUTL, Y_SC_R3);
        expect_val(32'h003); check("col_left_out", 32'(vif.rom_addr));

        // Blink: latch mid-frame 0, frames advance on (0,0) pixel ticks
        ganadorX = 1'b1;
        tick();
        ganadorX = 1'b0;
        expect_val(32'(GREEN));
        show_pixel(X_COL8, Y_TITLE, 8'hFF);
        check("blink_f0", 32'(vif.text_rgb));
        expect_val(32'h2);   check("blink_f0_on", 32'(vif.text_on_winner));
        frame_step();
        expect_val(32'(GREEN));
        show_pixel(X_COL8, Y_TITLE, 8'hFF);
        check("blink_f1", 32'(vif.text_rgb));
        frame_step();
        expect_val(32'(BLACK));
        show_pixel(X_COL8, Y_TITLE, 8'hFF);
        check("blink_f2", 32'(vif.text_rgb));
        expect_val(32'(WHITE));
        show_pixel(X_COL2, Y_SCORE, 8'hFF);
        check("blink_f2_score", 32'(vif.text_rgb));
        frame_step();
        expect_val(32'(BLACK));
        show_pixel(X_COL8, Y_TITLE, 8'hFF);
        check("blink_f3", 32'(vif.text_rgb));
        expect_val(32'(WHITE));
        show_pixel(X_COL2, Y_SCORE, 8'hFF);
        check("blink_f3_score", 32'(vif.text_rgb));
        frame_step();
        expect_val(32'(GREEN));
        show_pixel(X_COL8, Y_TITLE, 8'hFF);
        check("blink_f4", 32'(vif.text_rgb));

        // Pipeline latency and freeze, OWIN title
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        ganadorO = 1'b1;
        tick();
        ganadorO = 1'b0;
        expect_val(32'd2);   check("owin2_score_o", 32'(score_o));
        expect_val(32'(BLACK));
        show_pixel(X_COL8, Y_BLANK, 8'hFF);
        check("outside_rows_black", 32'(vif.text_rgb));
        vif.pixel_tick = 1'b1; vif.pix_x = X_COL8; vif.pix_y = Y_TITLE; vif.font_word = 8'hFF;
        expect_val(32'(BLACK));
        tick();
        check("latency_1tick", 32'(vif.text_rgb));
        expect_val(32'(GREEN));
        tick();
        check("latency_2tick", 32'(vif.text_rgb));
        vif.pixel_tick = 1'b0; vif.pix_x = X_COL8; vif.pix_y = Y_BLANK; vif.font_word = 8'h00;
        expect_val(32'(GREEN)); expect_val(32'h2);
        repeat (5) tick();
        check("freeze_rgb", 32'(vif.text_rgb));
        check("freeze_on", 32'(vif.text_on_winner));
        vif.pixel_tick = 1'b1;
        expect_val(32'(BLACK));
        tick();
        vif.pixel_tick = 1'b0;
        check("resume_rgb", 32'(vif.text_rgb));
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h4F0); check("owin2_title_char", 32'(vif.rom_addr));

        // Reset during XWIN with score_x=3 beats every coincident event
        reset = 1'b1;
        tick();
        reset = 1'b0;
        x_round();
        x_round();
        ganadorX = 1'b1;
        tick();
        ganadorX = 1'b0;
        expect_val(32'd3);   check("pre_reset_score_x", 32'(score_x));
        expect_val(32'(GREEN));
        show_pixel(X_COL8, Y_TITLE, 8'hFF);
        check("pre_reset_rgb", 32'(vif.text_rgb));
        reset = 1'b1; ganadorO = 1'b1; new_game = 1'b0;
        vif.pixel_tick = 1'b1; vif.pix_x = '0; vif.pix_y = '0;
        tick();
        reset = 1'b0; ganadorO = 1'b0; vif.pixel_tick = 1'b0;
        expect_val(32'd0);   check("reset_mid_score_x", 32'(score_x));
        expect_val(32'd0);   check("reset_mid_score_o", 32'(score_o));
        expect_val(32'd0);   check("reset_mid_rgb", 32'(vif.text_rgb));
        expect_val(32'd0);   check("reset_mid_on", 32'(vif.text_on_winner));
        peek_rom(X_COL8, Y_TITLE);
        expect_val(32'h000); check("reset_mid_title", 32'(vif.rom_addr));
        tick();
        expect_val(32'd0);   check("post_reset_score_o", 32'(score_o));

        if (exp_q.size() != 0) begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d leftover entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
